// File: rtl/el2_mubi_pkg.sv
// Multi-bit boolean encoding shared by the lockstep control logic.
// Only the exact True pattern counts as true; every other value is treated as False.
package el2_mubi_pkg;
    typedef logic [3:0] el2_mubi_t;

    localparam el2_mubi_t MuBi4True  = 4'h6;
    localparam el2_mubi_t MuBi4False = 4'h9;

    function automatic logic mubi4_test_true_strict(el2_mubi_t val);
        return val == MuBi4True;
    endfunction
endpackage

// File: rtl/el2_pkg.sv
// Shared VeeR types used by the lockstep error controller.
package el2_pkg;
    typedef enum logic [2:0] {
        ST_RST_WAIT,
        ST_WARMUP,
        ST_ARMED,
        ST_INJ_WAIT,
        ST_DISABLED,
        ST_ALERT,
        ST_LOCKED
    } el2_dcls_state_e;
endpackage

// File: rtl/el2_dcls_err_ctrl_if.sv
// Comparator result/enable and SoC alert handshake between the lockstep controller and its neighbours.
interface el2_dcls_err_ctrl_if;
    logic cmp_valid_i;
    logic cmp_mismatch_i;
    logic cmp_en_o;
    logic alert_req_o;
    logic alert_ack_i;

    modport master (
        input  cmp_valid_i,
        input  cmp_mismatch_i,
        input  alert_ack_i,
        output cmp_en_o,
        output alert_req_o
    );

    modport slave (
        output cmp_valid_i,
        output cmp_mismatch_i,
        output alert_ack_i,
        input  cmp_en_o,
        input  alert_req_o
    );
endinterface

// File: rtl/el2_dcls_timer.sv
// Load/count/expire counter; expire_o flags the cycle in which the count sits at limit_i.
module el2_dcls_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)                         cnt_d = '0;
        else if (en_i && cnt_q != limit_i)  cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == limit_i);
endmodule

// File: rtl/el2_dcls_err_ctrl.sv
// DCLS comparison sequencer: gates the comparator through reset/warm-up/disable,
// counts mismatches, runs injection self-tests and escalates to a sticky alert.
module el2_dcls_err_ctrl
    import el2_mubi_pkg::*;
    import el2_pkg::*;
#(
    parameter int DELAY      = 3,
    parameter int WARMUP     = 8,
    parameter int ERR_THRESH = 1,
    parameter int CNT_W      = 8,
    parameter int INJ_TMO    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_rst_l_i,
    input  el2_mubi_t            disable_detection_i,
    input  el2_mubi_t            inj_en_i,
    input  logic                 inj_req_i,
    el2_dcls_err_ctrl_if.master  bus,
    output logic                 inj_o,
    output logic                 inj_fail_o,
    output el2_mubi_t            corruption_detected_o,
    output logic [CNT_W-1:0]     mismatch_cnt_o
);
    // Windows never shorter than the shadow lag, or the comparator would see stale shadow state.
    localparam int WARM_CYC = (WARMUP  > DELAY)     ? WARMUP  : DELAY + 1;
    localparam int INJ_CYC  = (INJ_TMO > DELAY + 1) ? INJ_TMO : DELAY + 2;
    localparam int TMR_MAX  = (WARM_CYC > INJ_CYC)  ? WARM_CYC : INJ_CYC;
    localparam int TW       = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ERR_THRESH);

    el2_dcls_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inj_q, inj_d, fail_q, fail_d;
    el2_mubi_t        corr_q, corr_d;
    logic             dis, inj_ok, mism, core_rst, tmr_en, tmr_exp;
    logic [TW-1:0]    tmr_lim;

    assign dis      = mubi4_test_true_strict(disable_detection_i);
    assign inj_ok   = mubi4_test_true_strict(inj_en_i);
    assign mism     = bus.cmp_valid_i & bus.cmp_mismatch_i;
    assign core_rst = ~core_rst_l_i;
    assign tmr_en   = (state_q == ST_WARMUP) || (state_q == ST_INJ_WAIT);
    assign tmr_lim  = (state_q == ST_INJ_WAIT) ? TW'(INJ_CYC - 1) : TW'(WARM_CYC - 1);

    // Any state change restarts the timer, so both windows begin at zero on entry.
    el2_dcls_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_d != state_q),
        .en_i     (tmr_en),
        .limit_i  (tmr_lim),
        .expire_o (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RST_WAIT;
            cnt_q   <= '0;
            inj_q   <= 1'b0;
            fail_q  <= 1'b0;
            corr_q  <= MuBi4False;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inj_q   <= inj_d;
            fail_q  <= fail_d;
            corr_q  <= corr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RST_WAIT: if (core_rst_l_i) state_d = ST_WARMUP;
            ST_WARMUP: begin
                if (core_rst)     state_d = ST_RST_WAIT;
                else if (tmr_exp) state_d = dis ? ST_DISABLED : ST_ARMED;
            end
            // A reached threshold outranks disable and injection requests.
            ST_ARMED: begin
                if (core_rst)                          state_d = ST_RST_WAIT;
                else if (cnt_q >= THRESH)              state_d = ST_ALERT;
                else if (dis)                          state_d = ST_DISABLED;
                else if (inj_req_i && inj_ok && !mism) state_d = ST_INJ_WAIT;
            end
            ST_INJ_WAIT: begin
                if (core_rst)     state_d = ST_RST_WAIT;
                else if (dis)     state_d = ST_DISABLED;
                else if (mism)    state_d = ST_ARMED;
                else if (tmr_exp) state_d = ST_ALERT;
            end
            ST_DISABLED: begin
                if (core_rst)  state_d = ST_RST_WAIT;
                else if (!dis) state_d = ST_WARMUP;
            end
            ST_ALERT:  if (bus.alert_ack_i) state_d = ST_LOCKED;
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_RST_WAIT;
        endcase
    end

    always_comb begin
        bus.cmp_en_o    = (state_q == ST_ARMED) || (state_q == ST_INJ_WAIT);
        bus.alert_req_o = (state_q == ST_ALERT);
        inj_d  = (state_q == ST_ARMED) && (state_d == ST_INJ_WAIT);
        fail_d = fail_q || ((state_q == ST_INJ_WAIT) && (state_d == ST_ALERT));
        corr_d = (state_d == ST_ALERT) ? MuBi4True : corr_q;
        cnt_d  = cnt_q;
        if (core_rst && state_q != ST_ALERT && state_q != ST_LOCKED)
            cnt_d = '0;
        else if (state_q == ST_ARMED && mism && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign inj_o                 = inj_q;
    assign inj_fail_o            = fail_q;
    assign corruption_detected_o = corr_q;
    assign mismatch_cnt_o        = cnt_q;
endmodule

// File: tb/tb_el2_dcls_err_ctrl.sv
// Bench for el2_dcls_err_ctrl: two instances (thresholds 1 and 3) share stimulus and are
// checked every cycle against a count-down phase model, plus literal scenario checks.
module tb_el2_dcls_err_ctrl;
    import el2_mubi_pkg::*;

    localparam int WARM_CYC = 8;
    localparam int INJ_CYC  = 6;
    localparam int CMAX     = 255;
    localparam int P_IDLE = 0, P_WARM = 1, P_ARMED = 2, P_INJ = 3, P_OFF = 4, P_ALERT = 5, P_LOCK = 6;

    typedef struct packed {
        int   ph;
        int   left;
        int   cnt;
        logic inj;
        logic fail;
        logic corr;
    } mdl_t;

    logic clk, rst, crl, req, cv, cm, ack;
    el2_mubi_t dis, ie;
    logic inj_a, fail_a, inj_b, fail_b;
    el2_mubi_t corr_a, corr_b;
    logic [7:0] cnt_a, cnt_b;
    int checks = 0, failures = 0;
    logic cmp_on = 1'b0;
    mdl_t ma, mb;

    el2_dcls_err_ctrl_if ifa();
    el2_dcls_err_ctrl_if ifb();
    assign ifa.cmp_valid_i = cv;  assign ifa.cmp_mismatch_i = cm;  assign ifa.alert_ack_i = ack;
    assign ifb.cmp_valid_i = cv;  assign ifb.cmp_mismatch_i = cm;  assign ifb.alert_ack_i = ack;

    el2_dcls_err_ctrl #(.ERR_THRESH(1)) dut_a (
        .clk(clk), .rst(rst), .core_rst_l_i(crl), .disable_detection_i(dis), .inj_en_i(ie),
        .inj_req_i(req), .bus(ifa), .inj_o(inj_a), .inj_fail_o(fail_a),
        .corruption_detected_o(corr_a), .mismatch_cnt_o(cnt_a));

    el2_dcls_err_ctrl #(.ERR_THRESH(3)) dut_b (
        .clk(clk), .rst(rst), .core_rst_l_i(crl), .disable_detection_i(dis), .inj_en_i(ie),
        .inj_req_i(req), .bus(ifb), .inj_o(inj_b), .inj_fail_o(fail_b),
        .corruption_detected_o(corr_b), .mismatch_cnt_o(cnt_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1);
    end

    // Phase model: windows count down from their length; leaving one early just drops it.
    function automatic mdl_t step(input mdl_t m, input int thr, input logic c_on, input logic d,
                                  input logic ien, input logic rq, input logic mm, input logic ak);
        mdl_t n;
        n = m;
        n.inj = 1'b0;
        if (m.ph == P_IDLE) begin
            if (c_on) begin n.ph = P_WARM; n.left = WARM_CYC; end
        end else if (m.ph != P_ALERT && m.ph != P_LOCK && !c_on) begin
            n.ph = P_IDLE; n.cnt = 0;
        end else if (m.ph == P_WARM) begin
            n.left = m.left - 1;
            if (n.left == 0) n.ph = d ? P_OFF : P_ARMED;
        end else if (m.ph == P_ARMED) begin
            if (mm && m.cnt < CMAX) n.cnt = m.cnt + 1;
            if (m.cnt >= thr)            n.ph = P_ALERT;
            else if (d)                  n.ph = P_OFF;
            else if (rq && ien && !mm) begin n.ph = P_INJ; n.inj = 1'b1; n.left = INJ_CYC; end
        end else if (m.ph == P_INJ) begin
            n.left = m.left - 1;
            if (d)                 n.ph = P_OFF;
            else if (mm)           n.ph = P_ARMED;
            else if (n.left == 0) begin n.ph = P_ALERT; n.fail = 1'b1; end
        end else if (m.ph == P_OFF) begin
            if (!d) begin n.ph = P_WARM; n.left = WARM_CYC; end
        end else if (m.ph == P_ALERT) begin
            if (ak) n.ph = P_LOCK;
        end
        if (n.ph == P_ALERT) n.corr = 1'b1;
        return n;
    endfunction

    function automatic logic [15:0] exp_out(input mdl_t m);
        return {(m.ph == P_ARMED || m.ph == P_INJ), m.inj, (m.ph == P_ALERT), m.fail,
                (m.corr ? MuBi4True : MuBi4False), 8'(m.cnt)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, 1, crl, dis == MuBi4True, ie == MuBi4True, req, cv & cm, ack);
            mb <= step(mb, 3, crl, dis == MuBi4True, ie == MuBi4True, req, cv & cm, ack);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs bundled as {cmp_en, inj, alert_req, inj_fail, corruption[3:0], count[7:0]}.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_a", {16'h0, ifa.cmp_en_o, inj_a, ifa.alert_req_o, fail_a, corr_a, cnt_a},
                {16'h0, exp_out(ma)});
            chk("model_b", {16'h0, ifb.cmp_en_o, inj_b, ifb.alert_req_o, fail_b, corr_b, cnt_b},
                {16'h0, exp_out(mb)});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic warm(input string tag);
        rst = 1'b0; crl = 1'b1;
        repeat (8) tick();
        chk({tag, "_en_before"}, 32'(ifa.cmp_en_o), 0);
        tick();
        chk({tag, "_en_after"}, 32'(ifa.cmp_en_o), 1);
    endtask

    task automatic restart();
        rst = 1'b1; crl = 1'b0; dis = MuBi4False; ie = MuBi4False;
        req = 1'b0; cv = 1'b0; cm = 1'b0; ack = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        restart();
        tick();
        cmp_on = 1'b1;
        chk("rst_cmp_en", 32'(ifa.cmp_en_o), 0);
        chk("rst_alert",  32'(ifa.alert_req_o), 0);
        chk("rst_corr",   32'(corr_a), 32'(MuBi4False));
        chk("rst_cnt",    32'(cnt_a), 0);

        // Warm-up, then a single mismatch: alert on A, only a count on B.
        warm("s1");
        chk("s1_corr", 32'(corr_a), 32'(MuBi4False));
        cv = 1'b1; cm = 1'b1; tick(); cv = 1'b0; cm = 1'b0;
        chk("s2_cnt", 32'(cnt_a), 1);
        chk("s2_alert_early", 32'(ifa.alert_req_o), 0);
        tick();
        chk("s2_alert", 32'(ifa.alert_req_o), 1);
        chk("s2_corr", 32'(corr_a), 32'(MuBi4True));
        chk("s2_thr3_quiet", 32'(ifb.alert_req_o), 0);
        repeat (3) tick();
        chk("s2_alert_hold", 32'(ifa.alert_req_o), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("s2_acked", 32'(ifa.alert_req_o), 0);
        chk("s2_corr_sticky", 32'(corr_a), 32'(MuBi4True));
        chk("s6_b_cnt1", 32'(cnt_b), 1);

        // Core reset: B drops its count, locked A keeps its flag.
        crl = 1'b0; tick();
        chk("s6_b_cnt0", 32'(cnt_b), 0);
        chk("s6_b_en", 32'(ifb.cmp_en_o), 0);
        crl = 1'b1; tick();
        chk("s6_a_corr", 32'(corr_a), 32'(MuBi4True));

        // Injection answered by the expected mismatch four cycles later.
        restart(); warm("s3");
        ie = MuBi4True; req = 1'b1; tick(); req = 1'b0;
        chk("s3_inj", 32'(inj_a), 1);
        tick();
        chk("s3_inj_pulse", 32'(inj_a), 0);
        repeat (2) tick();
        cv = 1'b1; cm = 1'b1; tick(); cv = 1'b0; cm = 1'b0;
        chk("s3_cnt", 32'(cnt_a), 0);
        repeat (2) tick();
        chk("s3_no_alert", 32'(ifa.alert_req_o), 0);
        chk("s3_en", 32'(ifa.cmp_en_o), 1);

        // Injection left unanswered times out into an alert.
        req = 1'b1; tick(); req = 1'b0;
        repeat (5) tick();
        chk("s4_fail_early", 32'(fail_a), 0);
        tick();
        chk("s4_fail", 32'(fail_a), 1);
        chk("s4_alert", 32'(ifa.alert_req_o), 1);
        chk("s4_b_alert", 32'(ifb.alert_req_o), 1);

        // Invalid encoding is not a disable; True disables; False re-warms.
        restart(); warm("s5");
        dis = 4'h5; repeat (3) tick();
        chk("s5_invalid", 32'(ifa.cmp_en_o), 1);
        dis = MuBi4True; tick();
        chk("s5_off", 32'(ifa.cmp_en_o), 0);
        cv = 1'b1; cm = 1'b1; repeat (2) tick(); cv = 1'b0; cm = 1'b0;
        chk("s5_ignored_cnt", 32'(cnt_a), 0);
        chk("s5_ignored_alert", 32'(ifa.alert_req_o), 0);
        dis = MuBi4False;
        repeat (8) tick();
        chk("s5_rewarm_before", 32'(ifa.cmp_en_o), 0);
        tick();
        chk("s5_rewarm_after", 32'(ifa.cmp_en_o), 1);

        // Randomised traffic with periodic full resets.
        for (int i = 0; i < 4000; i++) begin
            if (i % 160 == 0)      rst = 1'b1;
            else if (i % 160 == 2) rst = 1'b0;
            crl = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0:       dis = MuBi4True;
                    1, 2:    dis = MuBi4False;
                    default: dis = 4'($urandom);
                endcase
            end
            ie  = ($urandom_range(0, 3) != 0) ? MuBi4True : 4'($urandom);
            req = ($urandom_range(0, 5) == 0);
            cv  = 1'($urandom_range(0, 1));
            cm  = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
